// File: rtl/fb_pkg.sv
// Shared definitions for the framebuffer rectangle-fill engine:
// frame geometry defaults, pixel width and the fill FSM state type.
package fb_pkg;

  localparam int FB_W_DEFAULT = 320;
  localparam int FB_H_DEFAULT = 240;
  localparam int FB_PIX_W     = 8;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    FILL,
    DONE
  } fill_state_t;

endpackage

// File: rtl/fb_addr_gen.sv
// Address walker for rectangle fills: owns the row base address and the column/row counters,
// producing the current VRAM write address and a flag on the final pixel of the rectangle.
module fb_addr_gen
  import fb_pkg::*;
#(
  parameter int ADDR_W = 17,
  parameter int FB_W   = FB_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] base,
  input  logic [8:0]        x,
  input  logic [7:0]        y,
  input  logic [8:0]        w_eff,
  input  logic [7:0]        h_eff,
  output logic [ADDR_W-1:0] addr,
  output logic              last_pixel
);

  localparam logic [ADDR_W-1:0] PITCH = ADDR_W'(FB_W);

  logic [ADDR_W-1:0] row_addr;
  logic [8:0]        col;
  logic [7:0]        row;
  logic [ADDR_W-1:0] y_off;
  logic [ADDR_W-1:0] start_addr;
  logic              col_last;
  logic              row_last;

  // The row offset is formed one bit wider than the address, then wrapped like all other address math.
  assign y_off      = ADDR_W'((ADDR_W+1)'(y) * (ADDR_W+1)'(FB_W));
  assign start_addr = base + y_off + ADDR_W'(x);

  assign col_last   = (col == w_eff - 9'd1);
  assign row_last   = (row == h_eff - 8'd1);
  assign last_pixel = col_last && row_last;
  assign addr       = row_addr + ADDR_W'(col);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_addr <= '0;
      col      <= '0;
      row      <= '0;
    end else if (load) begin
      row_addr <= start_addr;
      col      <= '0;
      row      <= '0;
    end else if (step) begin
      if (col_last) begin
        col      <= '0;
        row_addr <= row_addr + PITCH;
        row      <= row + 8'd1;
      end else begin
        col      <= col + 9'd1;
      end
    end
  end

endmodule

// File: rtl/fb_rect_fill.sv
// fb_rect_fill: writes solid-colour rectangles into framebuffer VRAM, one pixel per clock.
// Define FB_RECT_FILL_CLIP_EN to clip rectangles to the frame; otherwise out-of-frame commands are rejected with err.
module fb_rect_fill
  import fb_pkg::*;
#(
  parameter int ADDR_W = 17,
  parameter int FB_W   = FB_W_DEFAULT,
  parameter int FB_H   = FB_H_DEFAULT
) (
  input  logic                CLK,
  input  logic                RESETN,
  input  logic [ADDR_W-1:0]   BASE_ADDR,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [8:0]          cmd_x,
  input  logic [7:0]          cmd_y,
  input  logic [8:0]          cmd_w,
  input  logic [7:0]          cmd_h,
  input  logic [FB_PIX_W-1:0] cmd_color,
  output logic                wr_en,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [FB_PIX_W-1:0] wr_data,
  output logic                busy,
  output logic                done,
  output logic                err
);

  fill_state_t state, state_next;

  logic [ADDR_W-1:0]   base_q;
  logic [8:0]          x_q, w_q, w_eff, w_eff_q;
  logic [7:0]          y_q, h_q, h_eff, h_eff_q;
  logic [FB_PIX_W-1:0] color_q;
  logic                reject, reject_q;
  logic                zero_size;
  logic [ADDR_W-1:0]   gen_addr;
  logic                last_pixel;

`ifdef FB_RECT_FILL_CLIP_EN
  logic [8:0] x_room;
  logic [7:0] y_room;

  // Clip to the frame edge; an origin outside the frame collapses to a zero-size fill.
  always_comb begin
    x_room = 9'(FB_W) - x_q;
    y_room = 8'(FB_H) - y_q;
    reject = 1'b0;
    w_eff  = '0;
    h_eff  = '0;
    if (x_q < 9'(FB_W)) w_eff = (w_q < x_room) ? w_q : x_room;
    if (y_q < 8'(FB_H)) h_eff = (h_q < y_room) ? h_q : y_room;
  end
`else
  always_comb begin
    reject = (({1'b0, x_q} + {1'b0, w_q}) > 10'(FB_W)) ||
             (({1'b0, y_q} + {1'b0, h_q}) > 9'(FB_H));
    w_eff  = w_q;
    h_eff  = h_q;
  end
`endif

  assign zero_size = (w_eff == '0) || (h_eff == '0);

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cmd_valid) state_next = SETUP;
      SETUP:   state_next = (reject || zero_size) ? DONE : FILL;
      FILL:    if (last_pixel) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Command fields and BASE_ADDR are captured once at accept so later input changes cannot disturb a fill.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      base_q   <= '0;
      x_q      <= '0;
      y_q      <= '0;
      w_q      <= '0;
      h_q      <= '0;
      color_q  <= '0;
      w_eff_q  <= '0;
      h_eff_q  <= '0;
      reject_q <= 1'b0;
    end else begin
      if (state == IDLE && cmd_valid) begin
        base_q  <= BASE_ADDR;
        x_q     <= cmd_x;
        y_q     <= cmd_y;
        w_q     <= cmd_w;
        h_q     <= cmd_h;
        color_q <= cmd_color;
      end
      if (state == SETUP) begin
        w_eff_q  <= w_eff;
        h_eff_q  <= h_eff;
        reject_q <= reject;
      end
    end
  end

  fb_addr_gen #(
    .ADDR_W (ADDR_W),
    .FB_W   (FB_W)
  ) u_addr_gen (
    .clk        (CLK),
    .rst_n      (RESETN),
    .load       (state == SETUP),
    .step       (state == FILL),
    .base       (base_q),
    .x          (x_q),
    .y          (y_q),
    .w_eff      (w_eff_q),
    .h_eff      (h_eff_q),
    .addr       (gen_addr),
    .last_pixel (last_pixel)
  );

  // Write port is driven straight from state so an asynchronous reset drops wr_en immediately.
  always_comb begin
    cmd_ready = (state == IDLE);
    wr_en     = (state == FILL);
    wr_addr   = (state == FILL) ? gen_addr : '0;
    wr_data   = (state == FILL) ? color_q : '0;
    busy      = (state != IDLE) || cmd_valid;
    done      = (state == DONE);
    err       = (state == DONE) && reject_q;
  end

endmodule

// File: tb/tb_fb_rect_fill.sv
// Directed self-checking bench for fb_rect_fill: reset values, fill sequencing, zero-size,
// out-of-frame, address wrap, back-to-back handshake and mid-fill reset.
module tb_fb_rect_fill;

  logic        CLK = 1'b0;
  logic        RESETN;
  logic [16:0] BASE_ADDR;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [8:0]  cmd_x;
  logic [7:0]  cmd_y;
  logic [8:0]  cmd_w;
  logic [7:0]  cmd_h;
  logic [7:0]  cmd_color;
  logic        wr_en;
  logic [16:0] wr_addr;
  logic [7:0]  wr_data;
  logic        busy;
  logic        done;
  logic        err;

  int checks = 0;
  int passed = 0;

  logic        en_log   [16];
  logic [16:0] addr_log [16];
  logic [7:0]  data_log [16];
  logic        done_log [16];
  logic        err_log  [16];
  logic        busy_log [16];
  logic        rdy_log  [16];

  int addr_a [6] = '{650, 651, 652, 970, 971, 972};

  fb_rect_fill dut (
    .CLK       (CLK),
    .RESETN    (RESETN),
    .BASE_ADDR (BASE_ADDR),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_x     (cmd_x),
    .cmd_y     (cmd_y),
    .cmd_w     (cmd_w),
    .cmd_h     (cmd_h),
    .cmd_color (cmd_color),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Presents a command at the start of a fresh cycle; that cycle is cycle 0 of the command.
  task automatic applyStimulus(input logic [16:0] base, input logic [8:0] x, input logic [7:0] y,
                               input logic [8:0] w, input logic [7:0] h, input logic [7:0] color);
    @(posedge CLK); #1;
    BASE_ADDR = base;
    cmd_x     = x;
    cmd_y     = y;
    cmd_w     = w;
    cmd_h     = h;
    cmd_color = color;
    cmd_valid = 1'b1;
  endtask

  // Samples outputs mid-cycle for cycles start..start+n-1; cmd_valid drops after cycle drop_at.
  task automatic capture(input int start, input int n, input int drop_at);
    for (int c = start; c < start + n; c++) begin
      @(negedge CLK);
      en_log[c]   = wr_en;
      addr_log[c] = wr_addr;
      data_log[c] = wr_data;
      done_log[c] = done;
      err_log[c]  = err;
      busy_log[c] = busy;
      rdy_log[c]  = cmd_ready;
      @(posedge CLK); #1;
      if (drop_at >= 0 && c >= drop_at) cmd_valid = 1'b0;
    end
  endtask

  initial begin
    RESETN    = 1'b0;
    BASE_ADDR = '0;
    cmd_valid = 1'b0;
    cmd_x     = '0;
    cmd_y     = '0;
    cmd_w     = '0;
    cmd_h     = '0;
    cmd_color = '0;

    // Reset values
    repeat (2) @(negedge CLK);
    RESETN = 1'b1;
    @(negedge CLK);
    checkOutput("rst_flags", {cmd_ready, wr_en, busy, done, err}, 5'b10000);
    checkOutput("rst_addr", wr_addr, 17'd0);
    checkOutput("rst_data", wr_data, 8'd0);

    // 3x2 fill at (10,2)
    applyStimulus(17'd0, 9'd10, 8'd2, 9'd3, 8'd2, 8'hA5);
    capture(0, 11, 0);
    for (int c = 0; c < 11; c++) begin
      checkOutput($sformatf("A_en_c%0d", c), en_log[c], (c >= 2 && c <= 7));
      checkOutput($sformatf("A_done_c%0d", c), done_log[c], (c == 8));
      checkOutput($sformatf("A_busy_c%0d", c), busy_log[c], (c <= 8));
      if (c >= 2 && c <= 7) begin
        checkOutput($sformatf("A_addr_c%0d", c), addr_log[c], 32'(addr_a[c-2]));
        checkOutput($sformatf("A_data_c%0d", c), data_log[c], 8'hA5);
      end
    end
    checkOutput("A_ready_c9", rdy_log[9], 1'b1);

    // Zero-width command
    applyStimulus(17'd0, 9'd0, 8'd0, 9'd0, 8'd5, 8'h55);
    capture(0, 4, 0);
    for (int c = 0; c < 4; c++) begin
      checkOutput($sformatf("B_en_c%0d", c), en_log[c], 1'b0);
      checkOutput($sformatf("B_done_c%0d", c), done_log[c], (c == 2));
      checkOutput($sformatf("B_err_c%0d", c), err_log[c], 1'b0);
      checkOutput($sformatf("B_ready_c%0d", c), rdy_log[c], (c == 0 || c == 3));
    end

    // Rectangle crossing the right edge
    applyStimulus(17'd0, 9'd318, 8'd0, 9'd4, 8'd1, 8'h3C);
    capture(0, 6, 0);
    for (int c = 0; c < 6; c++) begin
`ifdef FB_RECT_FILL_CLIP_EN
      checkOutput($sformatf("C_en_c%0d", c), en_log[c], (c == 2 || c == 3));
      checkOutput($sformatf("C_done_c%0d", c), done_log[c], (c == 4));
      checkOutput($sformatf("C_err_c%0d", c), err_log[c], 1'b0);
      if (c == 2 || c == 3)
        checkOutput($sformatf("C_addr_c%0d", c), addr_log[c], 32'(316 + c));
`else
      checkOutput($sformatf("C_en_c%0d", c), en_log[c], 1'b0);
      checkOutput($sformatf("C_done_c%0d", c), done_log[c], (c == 2));
      checkOutput($sformatf("C_err_c%0d", c), err_log[c], (c == 2));
`endif
    end

    // Base near the top of the address space wraps to zero
    applyStimulus(17'h1FFFF, 9'd0, 8'd0, 9'd2, 8'd1, 8'h5A);
    capture(0, 6, 0);
    checkOutput("D_en_c2", en_log[2], 1'b1);
    checkOutput("D_addr_c2", addr_log[2], 17'h1FFFF);
    checkOutput("D_en_c3", en_log[3], 1'b1);
    checkOutput("D_addr_c3", addr_log[3], 17'h00000);
    checkOutput("D_en_c4", en_log[4], 1'b0);
    checkOutput("D_done_c4", done_log[4], 1'b1);

    // Second command held on the bus during the first fill
    applyStimulus(17'd0, 9'd0, 8'd1, 9'd2, 8'd1, 8'h11);
    capture(0, 1, -1);
    BASE_ADDR = 17'h100;
    cmd_x     = 9'd5;
    cmd_y     = 8'd0;
    cmd_w     = 9'd1;
    cmd_h     = 8'd1;
    cmd_color = 8'h22;
    capture(1, 10, 5);
    for (int c = 1; c < 11; c++) begin
      checkOutput($sformatf("E_en_c%0d", c), en_log[c], (c == 2 || c == 3 || c == 7));
      checkOutput($sformatf("E_done_c%0d", c), done_log[c], (c == 4 || c == 8));
      checkOutput($sformatf("E_ready_c%0d", c), rdy_log[c], (c == 5 || c >= 9));
    end
    checkOutput("E_addr_c2", addr_log[2], 17'd320);
    checkOutput("E_data_c2", data_log[2], 8'h11);
    checkOutput("E_addr_c3", addr_log[3], 17'd321);
    checkOutput("E_data_c3", data_log[3], 8'h11);
    checkOutput("E_addr_c7", addr_log[7], 17'd261);
    checkOutput("E_data_c7", data_log[7], 8'h22);

    // Reset during the third write of a 10x10 fill
    applyStimulus(17'd0, 9'd0, 8'd0, 9'd10, 8'd10, 8'h77);
    capture(0, 4, 0);
    #1;
    checkOutput("F_en_before", wr_en, 1'b1);
    checkOutput("F_addr_before", wr_addr, 17'd2);
    RESETN = 1'b0;
    #1;
    checkOutput("F_en_async", wr_en, 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      checkOutput($sformatf("F_done_rst%0d", c), done, 1'b0);
    end
    RESETN = 1'b1;
    @(negedge CLK);
    checkOutput("F_flags_after", {cmd_ready, wr_en, busy, done, err}, 5'b10000);
    checkOutput("F_addr_after", wr_addr, 17'd0);
    checkOutput("F_data_after", wr_data, 8'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
